router_switch_alloc: RTL and testbench

ROUTER_SWITCH_ALLOC -- requirements
Module: router_switch_alloc

---
 rtl/router_switch_alloc_if.sv | 26 ++
 rtl/router_switch_alloc.sv | 179 +++++++++++++++++
 tb/tb_router_switch_alloc.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/router_switch_alloc_if.sv
// Port bundle for the 3x3 router switch allocator: head-flit requests and
// downstream ready in, per-input grant/fail and per-output crossbar selects out.
interface router_switch_alloc_if;
    logic [1:0] dst_x;
    logic [1:0] dst_y;
    logic [1:0] dst_local;
    logic [2:0] tail;
    logic [2:0] out_ready;
    logic [2:0] grant;
    logic [2:0] fail;
    logic [1:0] sel_x;
    logic [1:0] sel_y;
    logic [1:0] sel_local;
    logic [2:0] timeout;
    logic       err;

    modport master (
        output dst_x, dst_y, dst_local, tail, out_ready,
        input  grant, fail, sel_x, sel_y, sel_local, timeout, err
    );

    modport slave (
        input  dst_x, dst_y, dst_local, tail, out_ready,
        output grant, fail, sel_x, sel_y, sel_local, timeout, err
    );
endinterface

// File: rtl/router_switch_alloc.sv
// Switch allocator for a 3-port (X, Y, LOCAL) wormhole router: per-output
// round-robin arbitration, packet locking, hold watchdog and sticky error flag.
module router_switch_alloc #(
    parameter int HOLD_MAX = 15
) (
    input logic                  clk,
    input logic                  rst_n,
    router_switch_alloc_if.slave bus
);
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_LOCKED  = 1'b1;
    localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_MAX);

    // Internal port index p: 0 X, 1 Y, 2 LOCAL; external vectors carry p at bit (2-p).
    function automatic logic [1:0] next_port(input logic [1:0] p);
        case (p)
            2'd0:    next_port = 2'd1;
            2'd1:    next_port = 2'd2;
            2'd2:    next_port = 2'd0;
            default: next_port = 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
        logic [1:0] cand;
        logic       found;
        rr_pick = 2'd0;
        found   = 1'b0;
        cand    = (ptr == 2'd3) ? 2'd0 : ptr;
        for (int k = 0; k < 3; k++) begin
            if (!found && req[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
            cand = next_port(cand);
        end
    endfunction

    logic [2:0][1:0] dst_s;
    logic [2:0]      tail_s;
    logic [2:0]      ready_s;
    logic [2:0][2:0] req_s;
    logic [2:0]      req_any_s;
    logic [2:0]      hit_s;
    logic [2:0][1:0] win_s;
    logic [2:0]      tick_s;
    logic [2:0]      rel_tmo_s;
    logic [2:0]      err_hit_s;
    logic [2:0]      grant_s;
    logic [2:0]      fail_s;

    logic [2:0][0:0] state_r;
    logic [2:0][0:0] state_n_s;
    logic [2:0][1:0] owner_r;
    logic [2:0][1:0] owner_n_s;
    logic [2:0][1:0] ptr_r;
    logic [2:0][1:0] ptr_n_s;
    logic [2:0][7:0] cnt_r;
    logic [2:0][7:0] cnt_n_s;
    logic [2:0]      timeout_r;
    logic            err_r;

    assign dst_s[0]  = bus.dst_x;
    assign dst_s[1]  = bus.dst_y;
    assign dst_s[2]  = bus.dst_local;
    assign tail_s    = {bus.tail[0], bus.tail[1], bus.tail[2]};
    assign ready_s   = {bus.out_ready[0], bus.out_ready[1], bus.out_ready[2]};
    assign req_any_s = {|dst_s[0], |dst_s[1], |dst_s[2]};

    // Request matrix: req_s[o][p] when input p targets output o (code o+1).
    always_comb begin
        req_s = 9'd0;
        for (int o = 0; o < 3; o++) begin
            for (int p = 0; p < 3; p++) begin
                req_s[o][p] = (dst_s[p] == 2'(o + 1));
            end
        end
    end

    // Per-output arbitration and next-state computation.
    always_comb begin
        hit_s     = 3'b000;
        win_s     = owner_r;
        tick_s    = 3'b000;
        rel_tmo_s = 3'b000;
        err_hit_s = 3'b000;
        state_n_s = state_r;
        owner_n_s = owner_r;
        ptr_n_s   = ptr_r;
        cnt_n_s   = cnt_r;
        for (int o = 0; o < 3; o++) begin
            if (state_r[o] == ST_IDLE) begin
                win_s[o] = rr_pick(req_s[o], ptr_r[o]);
                if (ready_s[o] && (req_s[o] != 3'b000)) begin
                    hit_s[o] = 1'b1;
                    if (tail_s[win_s[o]]) begin
                        ptr_n_s[o] = next_port(win_s[o]);
                    end else begin
                        state_n_s[o] = ST_LOCKED;
                        owner_n_s[o] = win_s[o];
                        cnt_n_s[o]   = 8'd0;
                    end
                end else begin
                    hit_s[o] = 1'b0;
                end
            end else if (req_s[o][owner_r[o]] && ready_s[o]) begin
                hit_s[o]   = 1'b1;
                cnt_n_s[o] = 8'd0;
                if (tail_s[owner_r[o]]) begin
                    state_n_s[o] = ST_IDLE;
                    ptr_n_s[o]   = next_port(owner_r[o]);
                end else begin
                    state_n_s[o] = ST_LOCKED;
                end
            end else if (!req_s[o][owner_r[o]] && (dst_s[owner_r[o]] != 2'b00)) begin
                // Owner abandoned this packet mid-flight: flag it and free the output.
                err_hit_s[o] = 1'b1;
                state_n_s[o] = ST_IDLE;
                ptr_n_s[o]   = next_port(owner_r[o]);
                cnt_n_s[o]   = 8'd0;
            end else begin
                tick_s[o] = 1'b1;
            end

            if (tick_s[o]) begin
                if ((cnt_r[o] + 8'd1) == HOLD_LIMIT) begin
                    rel_tmo_s[o] = 1'b1;
                    state_n_s[o] = ST_IDLE;
                    ptr_n_s[o]   = next_port(owner_r[o]);
                    cnt_n_s[o]   = 8'd0;
                end else begin
                    cnt_n_s[o] = cnt_r[o] + 8'd1;
                end
            end else begin
                rel_tmo_s[o] = 1'b0;
            end
        end
    end

    // Collect per-input grants from the three outputs; requesters left out fail.
    always_comb begin
        grant_s = 3'b000;
        for (int o = 0; o < 3; o++) begin
            if (hit_s[o]) begin
                grant_s = grant_s | (3'b100 >> win_s[o]);
            end else begin
                grant_s = grant_s;
            end
        end
        fail_s = req_any_s & ~grant_s;
    end

    assign bus.grant     = rst_n ? grant_s : 3'b000;
    assign bus.fail      = rst_n ? fail_s : 3'b000;
    assign bus.sel_x     = (rst_n && hit_s[0]) ? (win_s[0] + 2'd1) : 2'd0;
    assign bus.sel_y     = (rst_n && hit_s[1]) ? (win_s[1] + 2'd1) : 2'd0;
    assign bus.sel_local = (rst_n && hit_s[2]) ? (win_s[2] + 2'd1) : 2'd0;
    assign bus.timeout   = {timeout_r[0], timeout_r[1], timeout_r[2]};
    assign bus.err       = err_r;

    // Allocator state registers; reset drops every lock immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= {ST_IDLE, ST_IDLE, ST_IDLE};
            owner_r   <= 6'd0;
            ptr_r     <= 6'd0;
            cnt_r     <= 24'd0;
            timeout_r <= 3'b000;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_n_s;
            owner_r   <= owner_n_s;
            ptr_r     <= ptr_n_s;
            cnt_r     <= cnt_n_s;
            timeout_r <= rel_tmo_s;
            err_r     <= err_r | (|err_hit_s);
        end
    end
endmodule

// File: tb/tb_router_switch_alloc.sv
// Self-checking bench for router_switch_alloc: per-cycle comparison against a
// behavioural allocator model, plus hand-computed expectations per scenario.
module tb_router_switch_alloc;
    localparam int HOLD = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    router_switch_alloc_if ifc();

    router_switch_alloc #(.HOLD_MAX(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: per output lock flag, owner, round-robin pointer, hold count.
    int   m_lock[3]  = '{0, 0, 0};
    int   m_owner[3] = '{0, 0, 0};
    int   m_ptr[3]   = '{0, 0, 0};
    int   m_cnt[3]   = '{0, 0, 0};
    bit   m_err      = 1'b0;
    logic [2:0] m_to = 3'b000;

    int   d[3];
    bit   tl[3];
    bit   rd[3];
    int   win;
    int   ow;
    logic [2:0] e_grant;
    logic [2:0] e_fail;
    logic [2:0] e_to;
    logic [2:0] n_to;
    logic       e_err;
    logic [1:0] e_sel[3];

    // Mid-cycle: derive expected outputs from the model, compare, then advance it.
    always @(negedge clk) begin
        d[0] = int'(ifc.dst_x);
        d[1] = int'(ifc.dst_y);
        d[2] = int'(ifc.dst_local);
        for (int p = 0; p < 3; p++) begin
            tl[p] = ifc.tail[2 - p];
            rd[p] = ifc.out_ready[2 - p];
        end
        e_grant = 3'b000;
        e_fail  = 3'b000;
        e_sel   = '{2'd0, 2'd0, 2'd0};
        e_to    = m_to;
        e_err   = m_err;
        if (!rst_n) begin
            e_to  = 3'b000;
            e_err = 1'b0;
            m_lock = '{0, 0, 0};
            m_ptr  = '{0, 0, 0};
            m_cnt  = '{0, 0, 0};
            m_err  = 1'b0;
            m_to   = 3'b000;
        end else begin
            n_to = 3'b000;
            for (int o = 0; o < 3; o++) begin
                win = -1;
                if (m_lock[o] == 0) begin
                    if (rd[o]) begin
                        for (int k = 0; k < 3; k++) begin
                            if (win < 0 && d[(m_ptr[o] + k) % 3] == o + 1) win = (m_ptr[o] + k) % 3;
                        end
                    end
                    if (win >= 0) begin
                        if (tl[win]) m_ptr[o] = (win + 1) % 3;
                        else begin
                            m_lock[o] = 1; m_owner[o] = win; m_cnt[o] = 0;
                        end
                    end
                end else begin
                    ow = m_owner[o];
                    if (d[ow] == o + 1 && rd[o]) begin
                        win = ow;
                        m_cnt[o] = 0;
                        if (tl[ow]) begin
                            m_lock[o] = 0; m_ptr[o] = (ow + 1) % 3;
                        end
                    end else if (d[ow] != 0 && d[ow] != o + 1) begin
                        m_err = 1'b1;
                        m_lock[o] = 0; m_ptr[o] = (ow + 1) % 3; m_cnt[o] = 0;
                    end else begin
                        m_cnt[o]++;
                        if (m_cnt[o] == HOLD) begin
                            m_lock[o] = 0; m_ptr[o] = (ow + 1) % 3; m_cnt[o] = 0;
                            n_to[2 - o] = 1'b1;
                        end
                    end
                end
                if (win >= 0) begin
                    e_grant[2 - win] = 1'b1;
                    e_sel[o] = 2'(win + 1);
                end
            end
            for (int p = 0; p < 3; p++) begin
                if (d[p] != 0 && !e_grant[2 - p]) e_fail[2 - p] = 1'b1;
            end
            m_to = n_to;
        end
        chk("mdl_grant", 8'(ifc.grant), 8'(e_grant));
        chk("mdl_fail", 8'(ifc.fail), 8'(e_fail));
        chk("mdl_sel_x", 8'(ifc.sel_x), 8'(e_sel[0]));
        chk("mdl_sel_y", 8'(ifc.sel_y), 8'(e_sel[1]));
        chk("mdl_sel_local", 8'(ifc.sel_local), 8'(e_sel[2]));
        chk("mdl_timeout", 8'(ifc.timeout), 8'(e_to));
        chk("mdl_err", 8'(ifc.err), 8'(e_err));
    end

    task automatic set_in(input logic [1:0] dx, input logic [1:0] dy, input logic [1:0] dl,
                          input logic [2:0] t, input logic [2:0] r);
        ifc.dst_x = dx; ifc.dst_y = dy; ifc.dst_local = dl;
        ifc.tail = t; ifc.out_ready = r;
    endtask

    // Apply one cycle of inputs just after the edge; return mid-cycle for checks.
    task automatic drive(input logic [1:0] dx, input logic [1:0] dy, input logic [1:0] dl,
                         input logic [2:0] t, input logic [2:0] r);
        @(posedge clk); #1;
        set_in(dx, dy, dl, t, r);
        @(negedge clk); #1;
    endtask

    // Reset pulse with live requests present: combinational outputs must stay quiet.
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        set_in(2'b01, 2'b10, 2'b11, 3'b000, 3'b111);
        @(negedge clk); #1;
        chk("rst_grant", 8'(ifc.grant), 8'(3'b000));
        chk("rst_fail", 8'(ifc.fail), 8'(3'b000));
        chk("rst_sel_x", 8'(ifc.sel_x), 8'(2'b00));
        chk("rst_err", 8'(ifc.err), 8'(1'b0));
        chk("rst_timeout", 8'(ifc.timeout), 8'(3'b000));
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_in(2'b00, 2'b00, 2'b00, 3'b000, 3'b111);
    endtask

    initial begin
        set_in(2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
        do_reset();

        // Round robin on output Y, all tails.
        drive(2'b10, 2'b10, 2'b10, 3'b111, 3'b111);
        chk("rr_c1_grant", 8'(ifc.grant), 8'(3'b100));
        chk("rr_c1_fail", 8'(ifc.fail), 8'(3'b011));
        chk("rr_c1_sel_y", 8'(ifc.sel_y), 8'(2'b01));
        drive(2'b10, 2'b10, 2'b10, 3'b111, 3'b111);
        chk("rr_c2_grant", 8'(ifc.grant), 8'(3'b010));
        chk("rr_c2_sel_y", 8'(ifc.sel_y), 8'(2'b10));
        drive(2'b10, 2'b10, 2'b10, 3'b111, 3'b111);
        chk("rr_c3_grant", 8'(ifc.grant), 8'(3'b001));
        chk("rr_c3_sel_y", 8'(ifc.sel_y), 8'(2'b11));
        drive(2'b10, 2'b10, 2'b10, 3'b111, 3'b111);
        chk("rr_c4_grant", 8'(ifc.grant), 8'(3'b100));

        // Downstream stalled: nobody granted, pointer (now Y) survives.
        for (int i = 0; i < 2; i++) begin
            drive(2'b10, 2'b10, 2'b10, 3'b111, 3'b000);
            chk("stall_grant", 8'(ifc.grant), 8'(3'b000));
            chk("stall_fail", 8'(ifc.fail), 8'(3'b111));
        end
        drive(2'b10, 2'b10, 2'b10, 3'b111, 3'b111);
        chk("stall_resume_grant", 8'(ifc.grant), 8'(3'b010));

        // Three distinct outputs at once, then all U-turns.
        drive(2'b01, 2'b11, 2'b10, 3'b111, 3'b111);
        chk("par_grant", 8'(ifc.grant), 8'(3'b111));
        chk("par_fail", 8'(ifc.fail), 8'(3'b000));
        chk("par_sel_x", 8'(ifc.sel_x), 8'(2'b01));
        chk("par_sel_y", 8'(ifc.sel_y), 8'(2'b11));
        chk("par_sel_local", 8'(ifc.sel_local), 8'(2'b10));
        drive(2'b01, 2'b10, 2'b11, 3'b111, 3'b111);
        chk("uturn_grant", 8'(ifc.grant), 8'(3'b111));
        chk("uturn_sel_y", 8'(ifc.sel_y), 8'(2'b10));

        // Packet lock on LOCAL held by X against a competing Y.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 2'b11, 2'b00, 3'b000, 3'b111);
            chk("lock_grant", 8'(ifc.grant), 8'(3'b100));
            chk("lock_fail", 8'(ifc.fail), 8'(3'b010));
        end
        drive(2'b11, 2'b11, 2'b00, 3'b100, 3'b111);
        chk("lock_tail_grant", 8'(ifc.grant), 8'(3'b100));
        drive(2'b11, 2'b11, 2'b00, 3'b000, 3'b111);
        chk("lock_next_grant", 8'(ifc.grant), 8'(3'b010));
        chk("lock_next_sel", 8'(ifc.sel_local), 8'(2'b10));
        drive(2'b00, 2'b11, 2'b00, 3'b010, 3'b111);

        // Watchdog: X locks Y then goes silent for HOLD cycles.
        do_reset();
        drive(2'b10, 2'b00, 2'b00, 3'b000, 3'b111);
        chk("wd_lock_grant", 8'(ifc.grant), 8'(3'b100));
        for (int i = 0; i < HOLD; i++) begin
            drive(2'b00, 2'b00, 2'b10, 3'b000, 3'b111);
            chk("wd_hold_grant", 8'(ifc.grant), 8'(3'b000));
            chk("wd_hold_timeout", 8'(ifc.timeout), 8'(3'b000));
        end
        drive(2'b00, 2'b00, 2'b10, 3'b111, 3'b111);
        chk("wd_timeout", 8'(ifc.timeout), 8'(3'b010));
        chk("wd_release_grant", 8'(ifc.grant), 8'(3'b001));
        chk("wd_release_sel", 8'(ifc.sel_y), 8'(2'b11));
        drive(2'b00, 2'b00, 2'b00, 3'b000, 3'b111);
        chk("wd_pulse_end", 8'(ifc.timeout), 8'(3'b000));

        // Owner redirects mid-packet: sticky err, LOCAL freed, X served on X.
        do_reset();
        drive(2'b11, 2'b00, 2'b00, 3'b000, 3'b111);
        drive(2'b01, 2'b00, 2'b00, 3'b000, 3'b111);
        chk("err_same_grant", 8'(ifc.grant), 8'(3'b100));
        chk("err_same_sel_x", 8'(ifc.sel_x), 8'(2'b01));
        chk("err_not_yet", 8'(ifc.err), 8'(1'b0));
        drive(2'b00, 2'b00, 2'b11, 3'b111, 3'b111);
        chk("err_set", 8'(ifc.err), 8'(1'b1));
        chk("err_local_free", 8'(ifc.grant), 8'(3'b001));
        drive(2'b00, 2'b00, 2'b00, 3'b000, 3'b111);
        chk("err_sticky", 8'(ifc.err), 8'(1'b1));
        do_reset();
        drive(2'b00, 2'b00, 2'b00, 3'b000, 3'b111);
        chk("err_cleared", 8'(ifc.err), 8'(1'b0));

        // Reset mid-packet drops the lock and rewinds the pointer to X.
        drive(2'b00, 2'b11, 2'b11, 3'b111, 3'b111);
        chk("mid_pre_grant", 8'(ifc.grant), 8'(3'b010));
        drive(2'b00, 2'b11, 2'b00, 3'b000, 3'b111);
        do_reset();
        drive(2'b11, 2'b11, 2'b11, 3'b111, 3'b111);
        chk("mid_post_grant", 8'(ifc.grant), 8'(3'b100));
        chk("mid_post_sel", 8'(ifc.sel_local), 8'(2'b01));

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
